// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide unit: operation codes, FSM state
// encodings, the per-operation run configuration latched at acceptance, and a
// helper that classifies signed operations.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // Operation codes presented on op together with start
   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_MADD  = 4'd2;
   localparam logic [3:0] OP_MADDU = 4'd3;
   localparam logic [3:0] OP_DIV   = 4'd4;
   localparam logic [3:0] OP_DIVU  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd7;

   // FSM state encodings
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // What the iterative datapath must do once the last bit has been processed
   typedef struct packed {
      logic is_div;    // restoring divide instead of shift-add multiply
      logic is_madd;   // accumulate product into {hi,lo}
      logic neg_lo;    // negate product / quotient
      logic neg_hi;    // negate remainder
   } run_cfg_t;

   // Operations whose operands are two's-complement values
   function automatic logic op_is_signed(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// All sign handling for the multiply/divide unit, purely combinational.
//   Operand side : converts a/b to magnitudes for signed ops and reports the
//                  sign of the product/quotient and of the remainder.
//   Result side  : conditionally negates the raw magnitude result held by the
//                  iteration register (full product, or {rem, quo}).
// Ports
//   i_op        operation code (selects signed vs unsigned interpretation)
//   i_a, i_b    raw operands
//   o_mag_a/b   operand magnitudes (unchanged for unsigned ops)
//   o_neg_prod  product / quotient must be negated
//   o_neg_rem   remainder must be negated (follows dividend sign)
//   i_raw       magnitude result {upper, lower}
//   i_neg_lo    negate full product / quotient
//   i_neg_hi    negate remainder
//   o_prod_fix  signed-corrected 2*WIDTH product
//   o_quo_fix   signed-corrected quotient (lower half of i_raw)
//   o_rem_fix   signed-corrected remainder (upper half of i_raw)
// -----------------------------------------------------------------------------
module muldiv_signfix
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]         i_op,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [WIDTH-1:0]   o_mag_a,
   output logic [WIDTH-1:0]   o_mag_b,
   output logic               o_neg_prod,
   output logic               o_neg_rem,
   input  logic [2*WIDTH-1:0] i_raw,
   input  logic               i_neg_lo,
   input  logic               i_neg_hi,
   output logic [2*WIDTH-1:0] o_prod_fix,
   output logic [WIDTH-1:0]   o_quo_fix,
   output logic [WIDTH-1:0]   o_rem_fix
);

   logic w_signed;
   logic w_sign_a;
   logic w_sign_b;

   assign w_signed = op_is_signed(i_op);
   assign w_sign_a = w_signed & i_a[WIDTH-1];
   assign w_sign_b = w_signed & i_b[WIDTH-1];

   // The most-negative value maps onto itself, which is still the correct
   // unsigned magnitude, so no special case is needed for it.
   assign o_mag_a    = w_sign_a ? -i_a : i_a;
   assign o_mag_b    = w_sign_b ? -i_b : i_b;
   assign o_neg_prod = w_sign_a ^ w_sign_b;
   assign o_neg_rem  = w_sign_a;

   assign o_prod_fix = i_neg_lo ? -i_raw : i_raw;
   assign o_quo_fix  = i_neg_lo ? -i_raw[WIDTH-1:0] : i_raw[WIDTH-1:0];
   assign o_rem_fix  = i_neg_hi ? -i_raw[2*WIDTH-1:WIDTH] : i_raw[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS-style Hi/Lo multiply/divide unit. Multiplies and divides run
// one bit per cycle on operand magnitudes; moves, divide-by-zero and unknown
// opcodes complete one edge after acceptance without entering RUN.
// WIDTH must be even and at least 8.
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while busy=0
//   op           operation code (muldiv_pkg OP_*), sampled with start
//   a, b         operands, latched at acceptance
//   busy         iterative operation in progress
//   done         one-cycle completion pulse
//   div_by_zero  qualifies done: divide issued with b=0
//   hi, lo       architectural Hi / Lo registers
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

   // Iteration state
   logic [0:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_prod;   // multiply: {partial, multiplier}; divide: {rem, quo}
   logic [WIDTH-1:0]     r_opnd;   // multiplicand or divisor magnitude
   run_cfg_t             r_cfg;

   // Architectural state and completion flags
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;
   logic                 r_dbz;

   // Single-cycle operations retire on the edge after acceptance
   logic                 r_qk_valid;
   logic                 r_qk_hi;
   logic                 r_qk_lo;
   logic                 r_qk_dbz;
   logic [WIDTH-1:0]     r_qk_data;

   // Sign handling
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic                 w_neg_prod;
   logic                 w_neg_rem;
   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   // One-bit step datapath
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_rem_sh;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_sub;
   logic [WIDTH-1:0]     w_rem_new;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_acc_sum;

   muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
      .i_op       (op),
      .i_a        (a),
      .i_b        (b),
      .o_mag_a    (w_mag_a),
      .o_mag_b    (w_mag_b),
      .o_neg_prod (w_neg_prod),
      .o_neg_rem  (w_neg_rem),
      .i_raw      (r_prod),
      .i_neg_lo   (r_cfg.neg_lo),
      .i_neg_hi   (r_cfg.neg_hi),
      .o_prod_fix (w_prod_fix),
      .o_quo_fix  (w_quo_fix),
      .o_rem_fix  (w_rem_fix)
   );

   // Shift-add multiply: add the multiplicand into the upper half when the
   // current multiplier LSB is set, then shift the whole register right. The
   // carry out of the add becomes the new top bit.
   assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

   // Restoring divide: shift the next dividend bit into the remainder and
   // subtract the divisor if it fits. The remainder stays below the divisor,
   // so a WIDTH-bit subtraction is exact whenever it is kept.
   assign w_rem_sh   = r_prod[2*WIDTH-1:WIDTH-1];
   assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
   assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opnd;
   assign w_rem_new  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
   assign w_div_next = {w_rem_new, r_prod[WIDTH-2:0], w_ge};

   // MADD accumulates into {hi,lo} as they stand at completion, wrapping
   assign w_acc_sum  = {r_hi, r_lo} + w_prod_fix;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_prod     <= '0;
         r_opnd     <= '0;
         r_cfg      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_dbz      <= 1'b0;
         r_qk_valid <= 1'b0;
         r_qk_hi    <= 1'b0;
         r_qk_lo    <= 1'b0;
         r_qk_dbz   <= 1'b0;
         r_qk_data  <= '0;
      end else begin
         r_done     <= 1'b0;
         r_dbz      <= 1'b0;
         r_qk_valid <= 1'b0;

         if (r_qk_valid) begin
            r_done <= 1'b1;
            r_dbz  <= r_qk_dbz;
            if (r_qk_hi) r_hi <= r_qk_data;
            if (r_qk_lo) r_lo <= r_qk_data;
         end

         if (r_state == ST_RUN) begin
            if (r_cnt == CNT_LAST) begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
               if (r_cfg.is_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else if (r_cfg.is_madd) begin
                  {r_hi, r_lo} <= w_acc_sum;
               end else begin
                  {r_hi, r_lo} <= w_prod_fix;
               end
            end else begin
               r_prod <= r_cfg.is_div ? w_div_next : w_mul_next;
               r_cnt  <= r_cnt + CW'(1);
            end
         end else if (start) begin
            // IDLE: accept. Also reached in the done cycle, giving back-to-back.
            r_qk_hi   <= 1'b0;
            r_qk_lo   <= 1'b0;
            r_qk_dbz  <= 1'b0;
            r_qk_data <= a;
            case (op)
               OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
                  r_opnd  <= w_mag_a;
                  r_cfg   <= '{is_div:  1'b0,
                               is_madd: (op == OP_MADD) || (op == OP_MADDU),
                               neg_lo:  w_neg_prod,
                               neg_hi:  1'b0};
               end
               OP_DIV, OP_DIVU: begin
                  if (b == '0) begin
                     r_qk_valid <= 1'b1;
                     r_qk_dbz   <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_cnt   <= '0;
                     r_prod  <= {{WIDTH{1'b0}}, w_mag_a};
                     r_opnd  <= w_mag_b;
                     r_cfg   <= '{is_div:  1'b1,
                                  is_madd: 1'b0,
                                  neg_lo:  w_neg_prod,
                                  neg_hi:  w_neg_rem};
                  end
               end
               OP_MTHI: begin
                  r_qk_valid <= 1'b1;
                  r_qk_hi    <= 1'b1;
               end
               OP_MTLO: begin
                  r_qk_valid <= 1'b1;
                  r_qk_lo    <= 1'b1;
               end
               default: begin
                  r_qk_valid <= 1'b1;
               end
            endcase
         end
      end
   end

   assign busy        = (r_state == ST_RUN);
   assign done        = r_done;
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors with hand-computed results. Stimulus pushes the expected
// response (hi, lo, div_by_zero, completion edge) into a queue; a monitor on
// the falling edge pops and compares each time done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    op = 4'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;   // number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           done_edge;
      int           tag;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int tag,
                        input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s tag=%0d actual=0x%0h required=0x%0h", name, tag, act, req);
      end
   endtask

   // Called just after a falling edge; start is sampled at the next rising edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                        input int lat, input int tag);
      exp_t e;
      op    = o;
      a     = av;
      b     = bv;
      start = 1'b1;
      e.hi        = eh;
      e.lo        = el;
      e.dbz       = ed;
      e.done_edge = cyc + 1 + lat;
      e.tag       = tag;
      sb_q.push_back(e);
      $display("issue tag=%0d op=%0d a=0x%h b=0x%h expect hi=0x%h lo=0x%h dbz=%0b edge=%0d",
               tag, o, av, bv, eh, el, ed, e.done_edge);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input int tag);
      int n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout tag=%0d actual_pending=%0d required=0", tag, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
            end else begin
               mon_e = sb_q.pop_front();
               check("done_edge", mon_e.tag, 64'(cyc), 64'(mon_e.done_edge));
               check("hi", mon_e.tag, 64'(hi), 64'(mon_e.hi));
               check("lo", mon_e.tag, 64'(lo), 64'(mon_e.lo));
               check("div_by_zero", mon_e.tag, 64'(div_by_zero), 64'(mon_e.dbz));
               check("busy_at_done", mon_e.tag, 64'(busy), 64'd0);
               $display("done tag=%0d edge=%0d hi=0x%h lo=0x%h dbz=%0b",
                        mon_e.tag, cyc, hi, lo, div_by_zero);
            end
         end else begin
            check("dbz_without_done", -1, 64'(div_by_zero), 64'd0);
         end
      end
   end

   // Stimulus
   initial begin
      int acc;
      int nd;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", 0, 64'(busy), 64'd0);
      check("reset_done", 0, 64'(done), 64'd0);
      check("reset_dbz",  0, 64'(div_by_zero), 64'd0);
      check("reset_hi",   0, 64'(hi), 64'd0);
      check("reset_lo",   0, 64'(lo), 64'd0);
      $display("reset hi=0x%h lo=0x%h busy=%0b", hi, lo, busy);

      // Signed multiply: -3 * 7 = -21
      issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1);
      wait_idle(60, 1);

      // Moves then unsigned accumulate with carry from lo into hi
      issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 2);
      wait_idle(10, 2);
      issue(OP_MTHI, 32'h00000000, 32'd0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1, 3);
      wait_idle(10, 3);
      issue(OP_MADDU, 32'd1, 32'd1, 32'h00000001, 32'h00000000, 1'b0, 33, 4);
      wait_idle(60, 4);

      // Signed divides: -7/2 = -3 rem -1; most-negative / -1
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 5);
      wait_idle(60, 5);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 6);
      wait_idle(60, 6);

      // Divide by zero leaves hi/lo untouched
      issue(OP_MTHI, 32'h11, 32'd0, 32'h00000011, 32'h80000000, 1'b0, 1, 7);
      wait_idle(10, 7);
      issue(OP_MTLO, 32'h22, 32'd0, 32'h00000011, 32'h00000022, 1'b0, 1, 8);
      wait_idle(10, 8);
      issue(OP_DIVU, 32'd5, 32'd0, 32'h00000011, 32'h00000022, 1'b1, 1, 9);
      wait_idle(10, 9);

      // Unknown opcode completes as a no-op
      issue(4'hF, 32'hABCDEF01, 32'd3, 32'h00000011, 32'h00000022, 1'b0, 1, 10);
      wait_idle(10, 10);

      // MULTU 0x10000 * 0x10000 = 2^32; stray start at edge 10 ignored,
      // operand changes after acceptance ignored, start in done cycle accepted.
      acc = cyc + 1;
      issue(OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33, 11);
      wait_cyc(acc + 5);
      check("busy_in_run", 11, 64'(busy), 64'd1);
      wait_cyc(acc + 9);
      op    = OP_MTLO;
      a     = 32'hDEADBEEF;
      b     = 32'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 32'h12345678;
      b     = 32'd9;
      wait_cyc(acc + 33);
      check("done_cycle_reached", 11, 64'(done), 64'd1);
      // 6 * -7 = -42
      issue(OP_MULT, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33, 12);
      wait_idle(80, 12);

      // Reset in the middle of a run aborts without a done pulse
      op    = OP_MULTU;
      a     = 32'd3;
      b     = 32'd5;
      start = 1'b1;
      acc   = cyc + 1;
      $display("issue tag=13 op=%0d a=0x%h b=0x%h (aborted by reset)", OP_MULTU, a, b);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(acc + 15);
      rst = 1'b1;
      #1;
      check("rst_busy", 13, 64'(busy), 64'd0);
      check("rst_hi",   13, 64'(hi), 64'd0);
      check("rst_lo",   13, 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("no_done_after_rst", 13, 64'(nd), 64'd0);

      // First operation after reset accumulates onto cleared hi/lo: 0 + 2*3
      issue(OP_MADD, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0, 33, 14);
      wait_idle(60, 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      errors++;
      checks++;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
